// File: rtl/project1_pkg.sv
// Shared definitions for project1 and its initiator-side loader: FSM states,
// nibble type, default strobe/gap timing and small sizing helpers.
package project1_pkg;

    localparam int DEFAULT_STROBE_CYCLES  = 5;
    localparam int DEFAULT_GAP_CYCLES     = 10;
    localparam int DEFAULT_TIMEOUT_CYCLES = 400;

    typedef logic [3:0] nibble_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_GAP    = 3'd4,
        ST_COMMIT = 3'd5,
        ST_WAIT_E = 3'd6,
        ST_DONE   = 3'd7
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bit width able to index v items, never less than one bit.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/project1_loader_pulse_timer.sv
// pulse_timer: loadable down-counter; o_term is high while the count is zero.
// Loading N-1 makes the current phase last exactly N cycles.
module pulse_timer #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    output logic          o_term
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_term = (r_count == '0);

endmodule

// File: rtl/project1_loader.sv
// project1_loader: plays a host-written (partA, partB) table into project1 as
// timed partC loads followed by a partD commit. Optional partE capture phase
// is built when PROJECT1_LOADER_CAPTURE_EN is defined.
module project1_loader
    import project1_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int STROBE_CYCLES  = DEFAULT_STROBE_CYCLES,
    parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int IW             = clog2_min1(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [3:0]    wr_a,
    input  logic [3:0]    wr_b,
    input  logic          wr_valid,
    input  logic          go,
    output logic          busy,
    output logic          done,
    output logic [3:0]    partA,
    output logic [3:0]    partB,
    output logic          partC,
    output logic          partD
`ifdef PROJECT1_LOADER_CAPTURE_EN
    ,
    input  logic [3:0]    partE,
    output logic [3:0]    e_capture,
    output logic          e_valid
`endif
);

    // One extra index bit so "past the last entry" is representable.
    localparam int IXW  = IW + 1;
    localparam int MAXC = max3(STROBE_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
    localparam int CW   = clog2_min1(MAXC);

    localparam logic [CW-1:0] LD_STROBE  = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] LD_GAP     = CW'(GAP_CYCLES - 1);
`ifdef PROJECT1_LOADER_CAPTURE_EN
    localparam logic [CW-1:0] LD_TIMEOUT = CW'(TIMEOUT_CYCLES - 1);
`endif

    state_t         r_state;
    state_t         w_state_next;

    nibble_t        r_tab_a [DEPTH];
    nibble_t        r_tab_b [DEPTH];
    logic [DEPTH-1:0] r_tab_v;
    logic [DEPTH-1:0] w_hit;
    logic           w_wr_ok;

    logic [IXW-1:0] r_idx;
    logic           w_found;
    logic [IXW-1:0] w_found_idx;
    logic [IW-1:0]  w_sel;

    logic           w_tmr_load;
    logic [CW-1:0]  w_tmr_val;
    logic           w_term;

    logic           r_busy, r_done, r_part_c, r_part_d;
    nibble_t        r_part_a, r_part_b;
    logic           w_busy_next, w_done_next, w_part_c_next, w_part_d_next;
    nibble_t        w_part_a_next, w_part_b_next;

    // ------------------------------------------------------------------
    // Entry table. Indices with no matching entry simply hit nothing, so
    // out-of-range writes fall away without extra logic.
    // ------------------------------------------------------------------
    assign w_wr_ok = (r_state == ST_IDLE) && wr_en;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign w_hit[gi] = w_wr_ok && (wr_idx == IW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tab_v <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_hit[i]) begin
                    r_tab_v[i] <= wr_valid;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_hit[i]) begin
                r_tab_a[i] <= wr_a;
                r_tab_b[i] <= wr_b;
            end
        end
    end

    // Lowest valid entry at or above the current index; SCAN jumps straight
    // there, so skipped entries cost no cycles and produce no bus activity.
    always_comb begin
        w_found     = 1'b0;
        w_found_idx = r_idx;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_tab_v[i] && (IXW'(i) >= r_idx)) begin
                w_found     = 1'b1;
                w_found_idx = IXW'(i);
            end
        end
    end

    assign w_sel = w_found_idx[IW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx <= '0;
        end else if (r_state == ST_IDLE) begin
            r_idx <= '0;
        end else if (r_state == ST_SCAN && w_found) begin
            r_idx <= w_found_idx;
        end else if (r_state == ST_GAP && w_term) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register / next-state / output decode.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (go) w_state_next = ST_SCAN;
            ST_SCAN:   w_state_next = w_found ? ST_SETUP : ST_COMMIT;
            ST_SETUP:  w_state_next = ST_STROBE;
            ST_STROBE: if (w_term) w_state_next = ST_GAP;
            ST_GAP:    if (w_term) w_state_next = ST_SCAN;
`ifdef PROJECT1_LOADER_CAPTURE_EN
            ST_COMMIT: if (w_term) w_state_next = ST_WAIT_E;
            ST_WAIT_E: if ((partE != 4'h0) || w_term) w_state_next = ST_DONE;
`else
            ST_COMMIT: if (w_term) w_state_next = ST_DONE;
`endif
            ST_DONE:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // The timer is reloaded on entry to each timed phase.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        if (w_state_next != r_state) begin
            case (w_state_next)
                ST_STROBE: begin w_tmr_load = 1'b1; w_tmr_val = LD_STROBE; end
                ST_GAP:    begin w_tmr_load = 1'b1; w_tmr_val = LD_GAP;    end
                ST_COMMIT: begin w_tmr_load = 1'b1; w_tmr_val = LD_STROBE; end
`ifdef PROJECT1_LOADER_CAPTURE_EN
                ST_WAIT_E: begin w_tmr_load = 1'b1; w_tmr_val = LD_TIMEOUT; end
`endif
                default:   begin w_tmr_load = 1'b0; w_tmr_val = '0;        end
            endcase
        end
    end

    pulse_timer #(
        .CW(CW)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_term     (w_term)
    );

    // Outputs are decoded from the next state and registered, so each
    // output lines up exactly with the state it belongs to.
    always_comb begin
        w_busy_next   = (w_state_next != ST_IDLE) && (w_state_next != ST_DONE);
        w_done_next   = (w_state_next == ST_DONE);
        w_part_c_next = (w_state_next == ST_STROBE);
        w_part_d_next = (w_state_next == ST_COMMIT);
        w_part_a_next = 4'h0;
        w_part_b_next = 4'h0;
        if (w_state_next == ST_SETUP) begin
            w_part_a_next = r_tab_a[w_sel];
            w_part_b_next = r_tab_b[w_sel];
        end else if (w_state_next == ST_STROBE || w_state_next == ST_GAP) begin
            w_part_a_next = r_part_a;
            w_part_b_next = r_part_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_part_c <= 1'b0;
            r_part_d <= 1'b0;
            r_part_a <= 4'h0;
            r_part_b <= 4'h0;
        end else begin
            r_busy   <= w_busy_next;
            r_done   <= w_done_next;
            r_part_c <= w_part_c_next;
            r_part_d <= w_part_d_next;
            r_part_a <= w_part_a_next;
            r_part_b <= w_part_b_next;
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign partA = r_part_a;
    assign partB = r_part_b;
    assign partC = r_part_c;
    assign partD = r_part_d;

`ifdef PROJECT1_LOADER_CAPTURE_EN
    nibble_t r_e_capture;
    logic    r_e_valid;

    // Cleared when a sequence starts; a timeout simply leaves them cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_e_capture <= 4'h0;
            r_e_valid   <= 1'b0;
        end else if (r_state == ST_IDLE && go) begin
            r_e_capture <= 4'h0;
            r_e_valid   <= 1'b0;
        end else if (r_state == ST_WAIT_E && partE != 4'h0) begin
            r_e_capture <= partE;
            r_e_valid   <= 1'b1;
        end
    end

    assign e_capture = r_e_capture;
    assign e_valid   = r_e_valid;
`endif

endmodule

// File: tb/tb_project1_loader.sv
// Directed bench for project1_loader: whole-sequence waveform traces compared
// cycle by cycle against hand-derived timelines.
module tb_project1_loader;

    localparam int S = 5;
    localparam int G = 10;
`ifdef PROJECT1_LOADER_CAPTURE_EN
    localparam int W_TO = 400;
`else
    localparam int W_TO = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [1:0] wr_idx = 2'd0;
    logic [3:0] wr_a = 4'h0;
    logic [3:0] wr_b = 4'h0;
    logic       wr_valid = 1'b0;
    logic       go = 1'b0;
    logic       busy, done, partC, partD;
    logic [3:0] partA, partB;
    logic       w_ev;
    logic [3:0] w_ec;
`ifdef PROJECT1_LOADER_CAPTURE_EN
    logic [3:0] part_e = 4'h0;
`else
    assign w_ev = 1'b0;
    assign w_ec = 4'h0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [16:0] tr     [0:599];
    logic [16:0] exp_tr [0:599];
    logic [3:0]  ea [0:3];
    logic [3:0]  eb [0:3];

    always #5 clk = ~clk;

    project1_loader #(
        .DEPTH(4), .STROBE_CYCLES(S), .GAP_CYCLES(G), .TIMEOUT_CYCLES(400)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_a(wr_a), .wr_b(wr_b), .wr_valid(wr_valid),
        .go(go), .busy(busy), .done(done),
        .partA(partA), .partB(partB), .partC(partC), .partD(partD)
`ifdef PROJECT1_LOADER_CAPTURE_EN
        , .partE(part_e), .e_capture(w_ec), .e_valid(w_ev)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {e_valid, e_capture, busy, done, partD, partC, partA, partB}
    function automatic logic [16:0] mk(input logic bz, input logic dn, input logic d,
                                       input logic c, input logic [3:0] a,
                                       input logic [3:0] b, input logic ev,
                                       input logic [3:0] ec);
        return {ev, ec, bz, dn, d, c, a, b};
    endfunction

    task automatic wr(input logic [1:0] idx, input logic [3:0] a, input logic [3:0] b,
                      input logic v);
        wr_en = 1'b1; wr_idx = idx; wr_a = a; wr_b = b; wr_valid = v;
        ea[idx] = a; eb[idx] = b;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Expected timeline: SCAN, per valid entry {SETUP, STROBE, GAP, SCAN},
    // COMMIT, optional WAIT_E, DONE, two idle cycles.
    task automatic build_exp(input logic [3:0] vmask, input int wait_e, input logic ev,
                             input logic [3:0] ec, output int n);
        n = 0;
        exp_tr[n] = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0); n++;
        for (int e = 0; e < 4; e++) begin
            if (vmask[e]) begin
                exp_tr[n] = mk(1'b1, 1'b0, 1'b0, 1'b0, ea[e], eb[e], 1'b0, 4'h0); n++;
                for (int s = 0; s < S; s++) begin
                    exp_tr[n] = mk(1'b1, 1'b0, 1'b0, 1'b1, ea[e], eb[e], 1'b0, 4'h0); n++;
                end
                for (int g = 0; g < G; g++) begin
                    exp_tr[n] = mk(1'b1, 1'b0, 1'b0, 1'b0, ea[e], eb[e], 1'b0, 4'h0); n++;
                end
                exp_tr[n] = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0); n++;
            end
        end
        for (int s = 0; s < S; s++) begin
            exp_tr[n] = mk(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0); n++;
        end
        for (int w = 0; w < wait_e; w++) begin
            exp_tr[n] = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0); n++;
        end
        exp_tr[n] = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, ev, ec); n++;
        for (int i = 0; i < 2; i++) begin
            exp_tr[n] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, ev, ec); n++;
        end
    endtask

    // Pulses go, then records ncyc cycles (cycle 0 = first cycle after the go edge).
    // inj_at: cycle to re-issue go + a write; rst_at: cycle to assert reset;
    // e_at: cycle from which partE carries 0x3 (capture build).
    task automatic run_seq(input int ncyc, input int e_at, input int inj_at, input int rst_at);
        go = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < ncyc; k++) begin
            go = 1'b0; wr_en = 1'b0;
            if (k == inj_at) begin
                go = 1'b1; wr_en = 1'b1; wr_idx = 2'd3;
                wr_a = 4'hF; wr_b = 4'hF; wr_valid = 1'b1;
            end
            reset = (k == rst_at);
`ifdef PROJECT1_LOADER_CAPTURE_EN
            part_e = (e_at >= 0 && k >= e_at) ? 4'h3 : 4'h0;
`else
            if (e_at > ncyc) $display("note: e_at unused in this build");
`endif
            @(negedge clk);
            tr[k] = mk(busy, done, partD, partC, partA, partB, w_ev, w_ec);
            @(posedge clk); #1;
        end
        go = 1'b0; wr_en = 1'b0; reset = 1'b0;
`ifdef PROJECT1_LOADER_CAPTURE_EN
        part_e = 4'h0;
`endif
    endtask

    task automatic cmp_trace(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s@%0d", tag, k), 32'(tr[k]), 32'(exp_tr[k]));
        end
        $display("trace %s: %0d cycles compared", tag, n);
    endtask

    task automatic load_std();
        wr(2'd0, 4'h1, 4'hA, 1'b1);
        wr(2'd1, 4'h2, 4'h5, 1'b1);
        wr(2'd2, 4'h4, 4'hE, 1'b1);
        wr(2'd3, 4'h8, 4'h6, 1'b1);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_partA", 32'(partA), 32'd0);
        check("rst_partB", 32'(partB), 32'd0);
        check("rst_partC", 32'(partC), 32'd0);
        check("rst_partD", 32'(partD), 32'd0);
        check("rst_evalid", 32'(w_ev), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // All four entries valid.
        load_std();
        build_exp(4'b1111, W_TO, 1'b0, 4'h0, n);
        run_seq(n, -1, -1, -1);
        cmp_trace("all_valid", n);

        // Entry 1 invalid; entry 0 rewritten in the same cycle as go.
        wr(2'd0, 4'hC, 4'h3, 1'b1);
        wr(2'd1, 4'h2, 4'h5, 1'b0);
        wr(2'd2, 4'h4, 4'hE, 1'b1);
        wr(2'd3, 4'h8, 4'h6, 1'b1);
        wr_en = 1'b1; wr_idx = 2'd0; wr_a = 4'h1; wr_b = 4'hA; wr_valid = 1'b1;
        ea[0] = 4'h1; eb[0] = 4'hA;
        build_exp(4'b1101, W_TO, 1'b0, 4'h0, n);
        run_seq(n, -1, -1, -1);
        cmp_trace("skip_e1", n);

        // No valid entries; capture build sees partE=3 in the 8th WAIT_E cycle.
        for (int i = 0; i < 4; i++) wr(2'(i), 4'h0, 4'h0, 1'b0);
`ifdef PROJECT1_LOADER_CAPTURE_EN
        build_exp(4'b0000, 8, 1'b1, 4'h3, n);
        run_seq(n, 1 + S + 7, -1, -1);
`else
        build_exp(4'b0000, 0, 1'b0, 4'h0, n);
        run_seq(n, -1, -1, -1);
`endif
        cmp_trace("none_valid", n);

        // go + write during a sequence are both ignored.
        load_std();
        build_exp(4'b1111, W_TO, 1'b0, 4'h0, n);
        run_seq(n, -1, 10, -1);
        cmp_trace("midseq_ignored", n);

        // Reset in the second STROBE truncates everything on the next edge.
        build_exp(4'b1111, W_TO, 1'b0, 4'h0, n);
        for (int k = 21; k < 26; k++) exp_tr[k] = '0;
        run_seq(26, -1, -1, 20);
        cmp_trace("reset_mid", 26);

        // Table was cleared by reset; reload and replay from entry 0.
        load_std();
        build_exp(4'b1111, W_TO, 1'b0, 4'h0, n);
        run_seq(n, -1, -1, -1);
        cmp_trace("replay", n);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
